// File: rtl/ftoi_seq.sv
// Multi-cycle IEEE-754 single to signed int32 converter, nearest/ties-away.
// Define FTOI_FLOOR_EN to add a per-op floor (round toward -inf) select.
module ftoi_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        order,
`ifdef FTOI_FLOOR_EN
  input  logic        floor,
`endif
  input  logic [31:0] rs1,
  output logic        accepted,
  output logic        done,
  output logic [31:0] rd
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_ROUND,
    S_DONE
  } state_t;

`ifdef FTOI_FLOOR_EN
  localparam int FW = 24;
`else
  localparam int FW = 1;
`endif

  state_t        r_state;
  state_t        w_next;
  logic [31:0]   r_op;
  logic [31:0]   r_rd;
  logic [30:0]   r_mag;
  logic          r_sign;
  logic          r_sat;
  logic          r_guard;

  logic [7:0]    w_e;
  logic [23:0]   w_m;
  logic          w_nan;
  logic [2:0]    w_lsh;
  logic [4:0]    w_ramt;
  logic [30:0]   w_lmag;
  logic [23+FW:0] w_rsh;
  logic          w_sat;
  logic [30:0]   w_mag;
  logic          w_guard;
  logic          w_inc;
  logic [31:0]   w_rmag;
  logic [31:0]   w_res;

`ifdef FTOI_FLOOR_EN
  logic          r_floor;
  logic          r_sticky;
  logic          w_sticky;
`endif

  assign accepted = (r_state == S_IDLE) && order;
  assign done     = (r_state == S_DONE);
  assign rd       = r_rd;

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (order) w_next = S_SHIFT;
      S_SHIFT: w_next = S_ROUND;
      S_ROUND: w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  assign w_e    = r_op[30:23];
  assign w_m    = {|w_e, r_op[22:0]};
  assign w_nan  = (w_e == 8'hFF) && (r_op[22:0] != 23'd0);
  // Low bits of (e-150) and (150-e); only used inside their valid ranges.
  assign w_lsh  = w_e[2:0] - 3'd6;
  assign w_ramt = 5'd22 - w_e[4:0];
  assign w_lmag = {7'd0, w_m} << w_lsh;
  assign w_rsh  = {w_m, {FW{1'b0}}} >> w_ramt;

  always_comb begin
    w_sat   = 1'b0;
    w_mag   = '0;
    w_guard = 1'b0;
`ifdef FTOI_FLOOR_EN
    w_sticky = 1'b0;
`endif
    if (w_nan || w_e >= 8'd158) begin
      w_sat = 1'b1;
    end else if (w_e >= 8'd150) begin
      w_mag = w_lmag;
    end else if (w_e >= 8'd126) begin
      w_mag   = {7'd0, w_rsh[23+FW:FW]};
      w_guard = w_rsh[FW-1];
`ifdef FTOI_FLOOR_EN
      w_sticky = |w_rsh[FW-2:0];
`endif
    end else begin
`ifdef FTOI_FLOOR_EN
      w_sticky = |r_op[30:0];
`endif
    end
  end

`ifdef FTOI_FLOOR_EN
  assign w_inc = r_floor ? (r_sign & (r_guard | r_sticky)) : r_guard;
`else
  assign w_inc = r_guard;
`endif

  assign w_rmag = {1'b0, r_mag} + {31'd0, w_inc};

  always_comb begin
    w_res = r_sign ? (~w_rmag + 32'd1) : w_rmag;
    if (r_sat) w_res = r_sign ? 32'h8000_0000 : 32'h7FFF_FFFF;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_rd    <= 32'h0;
    end else begin
      r_state <= w_next;
      if (r_state == S_ROUND) r_rd <= w_res;
    end
  end

  always_ff @(posedge clk) begin
    if (accepted) begin
      r_op <= rs1;
`ifdef FTOI_FLOOR_EN
      r_floor <= floor;
`endif
    end
    if (r_state == S_SHIFT) begin
      // NaN saturates positive regardless of its sign bit.
      r_sign  <= r_op[31] & ~w_nan;
      r_sat   <= w_sat;
      r_mag   <= w_mag;
      r_guard <= w_guard;
`ifdef FTOI_FLOOR_EN
      r_sticky <= w_sticky;
`endif
    end
  end

endmodule
